seq_multiplier_ctrl: RTL and testbench

Iterative shift-add multiplier controller for the MIPS `mult`/`multu` path. It time-shares one WIDTH-bit carry-select adder across three jobs: operand magnitude conversion, WIDTH accumulate-shift steps, and final 2W-bit negation. Results go to the HI/LO register pair. The block sits between the decode/stall logic, which issues `start` and watches `busy`, and the HI/LO writeback.

---
 rtl/seq_multiplier_ctrl_pkg.sv | 22 ++
 rtl/seq_multiplier_ctrl_if.sv | 27 ++
 rtl/seq_multiplier_ctrl_adder.sv | 47 ++++
 rtl/seq_multiplier_ctrl.sv | 157 +++++++++++++++
 tb/tb_seq_multiplier_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/seq_multiplier_ctrl_pkg.sv
// Shared definitions for the iterative shift-add multiplier controller:
// FSM encoding, default operand width and run-counter sizing.
package seq_multiplier_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int CNT_W         = $clog2(DEFAULT_WIDTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PREP_A = 3'd1,
      S_PREP_B = 3'd2,
      S_RUN    = 3'd3,
      S_NEG_LO = 3'd4,
      S_NEG_HI = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/seq_multiplier_ctrl_if.sv
// Request/result bundle between decode/stall logic and the multiplier.
interface seq_multiplier_ctrl_if
   import seq_multiplier_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;

   modport master (
      output start, is_signed, A, B,
      input  busy, done, Hi, Lo
   );

   modport slave (
      input  start, is_signed, A, B,
      output busy, done, Hi, Lo
   );

endinterface

// File: rtl/seq_multiplier_ctrl_adder.sv
// WIDTH-bit adder built by rippling the carry through 4-bit carry-select slices.
module cs_slice4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_sum,
   output logic       o_cout
);

   logic [4:0] w_s0;
   logic [4:0] w_s1;

   assign w_s0 = {1'b0, i_a} + {1'b0, i_b};
   assign w_s1 = {1'b0, i_a} + {1'b0, i_b} + 5'd1;
   assign {o_cout, o_sum} = i_cin ? w_s1 : w_s0;

endmodule

module carry_select_adder_w #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);

   localparam int NSL = WIDTH / 4;

   logic [NSL:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar g = 0; g < NSL; g++) begin : g_slice
      cs_slice4 u_slice (
         .i_a    (i_a[4*g +: 4]),
         .i_b    (i_b[4*g +: 4]),
         .i_cin  (w_c[g]),
         .o_sum  (o_sum[4*g +: 4]),
         .o_cout (w_c[g+1])
      );
   end

   assign o_cout = w_c[NSL];

endmodule

// File: rtl/seq_multiplier_ctrl.sv
// Sequential mult/multu controller: one shared adder does operand magnitude,
// WIDTH shift-add steps and the final two-half negation into HI/LO.
module seq_multiplier_ctrl
   import seq_multiplier_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   seq_multiplier_ctrl_if.slave  bus
);

   localparam int CW = cnt_width(WIDTH);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_p;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [CW-1:0]    r_cnt;
   logic             r_is_signed;
   logic             r_sign;
   logic             r_carry;
   logic             r_busy;
   logic             r_done;

   logic [WIDTH-1:0] w_add_a;
   logic [WIDTH-1:0] w_add_b;
   logic [WIDTH-1:0] w_sum;
   logic             w_cin;
   logic             w_cout;
   logic             w_neg_a;
   logic             w_neg_b;
   logic             w_accept;

   assign w_neg_a  = r_is_signed & r_a[WIDTH-1];
   assign w_neg_b  = r_is_signed & r_b[WIDTH-1];
   assign w_accept = bus.start & ((r_state == S_IDLE) | (r_state == S_DONE));

   // Negation is ~x + cin with add_b held at zero; pass-through is x + 0 + 0.
   always_comb begin
      w_add_a = r_p;
      w_add_b = '0;
      w_cin   = 1'b0;
      case (r_state)
         S_PREP_A: begin
            w_add_a = w_neg_a ? ~r_a : r_a;
            w_cin   = w_neg_a;
         end
         S_PREP_B: begin
            w_add_a = w_neg_b ? ~r_b : r_b;
            w_cin   = w_neg_b;
         end
         S_RUN: begin
            w_add_a = r_p;
            w_add_b = r_q[0] ? r_m : '0;
         end
         S_NEG_LO: begin
            w_add_a = r_sign ? ~r_q : r_q;
            w_cin   = r_sign;
         end
         S_NEG_HI: begin
            w_add_a = r_sign ? ~r_p : r_p;
            w_cin   = r_sign & r_carry;
         end
         default: ;
      endcase
   end

   carry_select_adder_w #(
      .WIDTH (WIDTH)
   ) u_adder (
      .i_a    (w_add_a),
      .i_b    (w_add_b),
      .i_cin  (w_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_m         <= '0;
         r_p         <= '0;
         r_q         <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_cnt       <= '0;
         r_is_signed <= 1'b0;
         r_sign      <= 1'b0;
         r_carry     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_a         <= bus.A;
                  r_b         <= bus.B;
                  r_is_signed <= bus.is_signed;
                  r_sign      <= bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                  r_p         <= '0;
                  r_busy      <= 1'b1;
                  r_state     <= S_PREP_A;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_PREP_A: begin
               r_m     <= w_sum;
               r_state <= S_PREP_B;
            end
            S_PREP_B: begin
               r_q     <= w_sum;
               r_cnt   <= CW'(WIDTH - 1);
               r_state <= S_RUN;
            end
            S_RUN: begin
               // {cout, sum, Q} >> 1 lands in {P, Q}.
               r_p <= {w_cout, w_sum[WIDTH-1:1]};
               r_q <= {w_sum[0], r_q[WIDTH-1:1]};
               if (r_cnt == '0) begin
                  r_state <= S_NEG_LO;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_NEG_LO: begin
               r_q     <= w_sum;
               r_carry <= w_cout;
               r_state <= S_NEG_HI;
            end
            S_NEG_HI: begin
               r_p     <= w_sum;
               r_hi    <= w_sum;
               r_lo    <= r_q;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.Hi   = r_hi;
   assign bus.Lo   = r_lo;

endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
// Directed bench for seq_multiplier_ctrl with a cycle-level reference model.
module tb_seq_multiplier_ctrl;

   localparam int W   = 32;
   localparam int LAT = 37;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   seq_multiplier_ctrl_if #(.WIDTH(W)) bus ();

   seq_multiplier_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   // Reference model: fixed latency, start honoured only when idle/done.
   logic [63:0] m_pend = '0;
   logic [63:0] m_res  = '0;
   int          m_k    = 0;
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_k    <= 0;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_res  <= '0;
      end else if (bus.start && !m_busy) begin
         m_pend <= product(bus.A, bus.B, bus.is_signed);
         m_k    <= 1;
         m_busy <= 1'b1;
         m_done <= 1'b0;
      end else if (m_busy) begin
         m_k <= m_k + 1;
         if (m_k == W + 4) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_res  <= m_pend;
         end
      end else begin
         m_done <= 1'b0;
      end
   end

   always @(negedge clk) begin
      chk("model_busy", {63'b0, bus.busy}, {63'b0, m_busy});
      chk("model_done", {63'b0, bus.done}, {63'b0, m_done});
      chk("model_hi",   {32'b0, bus.Hi},   {32'b0, m_res[63:32]});
      chk("model_lo",   {32'b0, bus.Lo},   {32'b0, m_res[31:0]});
   end

   task automatic start_now(input logic [31:0] a, input logic [31:0] b, input logic s, output int t0);
      bus.A         = a;
      bus.B         = b;
      bus.is_signed = s;
      bus.start     = 1'b1;
      t0            = cyc;
      @(posedge clk);
      #1 bus.start  = 1'b0;
   endtask

   task automatic go(input logic [31:0] a, input logic [31:0] b, input logic s, output int t0);
      @(posedge clk);
      #1;
      start_now(a, b, s, t0);
   endtask

   task automatic wait_done(input int t0, input string nm, input logic [31:0] eh, input logic [31:0] el);
      int  n    = 0;
      bit  seen = 1'b0;
      while (!seen && n < 60) begin
         @(negedge clk);
         n++;
         if (bus.done) seen = 1'b1;
      end
      chk({nm, "_done_seen"}, {63'b0, seen}, 64'd1);
      if (seen) begin
         chk({nm, "_latency"}, 64'(cyc - t0), 64'(LAT));
         chk({nm, "_hi"}, {32'b0, bus.Hi}, {32'b0, eh});
         chk({nm, "_lo"}, {32'b0, bus.Lo}, {32'b0, el});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1);
   end

   initial begin
      int t0;
      int t_ign;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {63'b0, bus.busy}, 64'd0);
      chk("rst_done", {63'b0, bus.done}, 64'd0);
      chk("rst_hi",   {32'b0, bus.Hi},   64'd0);
      chk("rst_lo",   {32'b0, bus.Lo},   64'd0);
      reset = 1'b0;

      go(32'd3, 32'd5, 1'b0, t0);
      wait_done(t0, "multu_3x5", 32'h0, 32'hF);

      go(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, t0);
      wait_done(t0, "multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

      go(32'hFFFF_FFF9, 32'd3, 1'b1, t0);
      wait_done(t0, "mult_m7x3", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

      go(32'h8000_0000, 32'h8000_0000, 1'b1, t0);
      wait_done(t0, "mult_minsq", 32'h4000_0000, 32'h0);

      go(32'h0, 32'hFFFF_FFFF, 1'b1, t0);
      wait_done(t0, "mult_zero_neg", 32'h0, 32'h0);
      start_now(32'd2, 32'd2, 1'b0, t0);
      wait_done(t0, "b2b_2x2", 32'h0, 32'd4);

      go(32'd7, 32'd9, 1'b0, t0);
      repeat (9) @(posedge clk);
      #1;
      start_now(32'd5, 32'd5, 1'b0, t_ign);
      wait_done(t0, "ignored_start", 32'h0, 32'd63);

      go(32'd7, 32'd9, 1'b0, t0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_busy", {63'b0, bus.busy}, 64'd1);
      reset = 1'b1;
      #1;
      chk("arst_busy", {63'b0, bus.busy}, 64'd0);
      chk("arst_done", {63'b0, bus.done}, 64'd0);
      chk("arst_hi",   {32'b0, bus.Hi},   64'd0);
      chk("arst_lo",   {32'b0, bus.Lo},   64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      go(32'd6, 32'd7, 1'b0, t0);
      wait_done(t0, "post_rst_6x7", 32'h0, 32'd42);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
